// File: rtl/wb_splitter_pkg.sv
// Shared definitions for the Wishbone 1-to-N splitter with timeout.
//  - FSM state encoding (IDLE / ACTIVE / RESP)
//  - clog2 helper used to size the timeout counter
package wb_splitter_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACTIVE = 2'd1;
  localparam logic [1:0] ST_RESP   = 2'd2;

  // Number of bits needed to hold values 0..value-1.
  function automatic int clog2(input int value);
    int res;
    res = 0;
    for (longint p = 1; p < value; p = p * 2) res++;
    return res;
  endfunction

endpackage

// File: rtl/wb_tmo_counter.sv
// Per-transaction timeout counter.
//  clk, rst : clock, synchronous active-high reset
//  clr      : returns the count to zero (held while the splitter is not ACTIVE)
//  en       : counts one per cycle, saturating at TIMEOUT_CYCLES
//  expired  : count equals TIMEOUT_CYCLES-1, i.e. the last cycle a slave may answer
module wb_tmo_counter #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en && (cnt != CNT_SAT)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expired = (cnt == CNT_LAST);

endmodule

// File: rtl/wb_splitter_tmo.sv
// Wishbone classic 1-to-N splitter with unmapped-index error, per-transaction
// timeout and sticky fault reporting.
//  wb_clk_i / wb_rst_i     : clock, synchronous active-high reset
//  m_wb_*                  : master-side port; ack/err are one-cycle registered pulses,
//                            dat_o holds the last acked slave data
//  s_wb_*                  : flattened slave-side ports, slave k at [k*W +: W]
//  fault_o/idx_o/tmo_o     : sticky record of the first unmapped access or timeout
//  fault_clr_i             : clears the fault record (a coincident new fault wins)
module wb_splitter_tmo
  import wb_splitter_pkg::*;
#(
  parameter int NUM_PERIPHERALS  = 4,
  parameter int ADDR_WIDTH       = 32,
  parameter int DATA_WIDTH       = 32,
  parameter int SEL_WIDTH        = 4,
  parameter int ADDR_SEL_LOW_BIT = 16,
  parameter int ADDR_SEL_BITS    = 4,
  parameter int TIMEOUT_CYCLES   = 255
) (
  input  logic                                  wb_clk_i,
  input  logic                                  wb_rst_i,
  input  logic                                  m_wb_cyc_i,
  input  logic                                  m_wb_stb_i,
  input  logic                                  m_wb_we_i,
  input  logic [SEL_WIDTH-1:0]                  m_wb_sel_i,
  input  logic [ADDR_WIDTH-1:0]                 m_wb_adr_i,
  input  logic [DATA_WIDTH-1:0]                 m_wb_dat_i,
  output logic [DATA_WIDTH-1:0]                 m_wb_dat_o,
  output logic                                  m_wb_ack_o,
  output logic                                  m_wb_err_o,
  output logic [NUM_PERIPHERALS-1:0]            s_wb_cyc_o,
  output logic [NUM_PERIPHERALS-1:0]            s_wb_stb_o,
  output logic [NUM_PERIPHERALS-1:0]            s_wb_we_o,
  output logic [NUM_PERIPHERALS*SEL_WIDTH-1:0]  s_wb_sel_o,
  output logic [NUM_PERIPHERALS*ADDR_WIDTH-1:0] s_wb_adr_o,
  output logic [NUM_PERIPHERALS*DATA_WIDTH-1:0] s_wb_dat_o,
  input  logic [NUM_PERIPHERALS*DATA_WIDTH-1:0] s_wb_dat_i,
  input  logic [NUM_PERIPHERALS-1:0]            s_wb_ack_i,
  input  logic [NUM_PERIPHERALS-1:0]            s_wb_err_i,
  output logic                                  fault_o,
  output logic [ADDR_SEL_BITS-1:0]              fault_idx_o,
  output logic                                  fault_tmo_o,
  input  logic                                  fault_clr_i
);

  localparam int                IDXW    = ADDR_SEL_BITS;
  localparam int                CNT_W   = clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IDXW:0]     NUM_EXT = (IDXW + 1)'(NUM_PERIPHERALS);

  logic [1:0]                 state, state_d;
  logic [IDXW-1:0]            idx_q, idx_in, fault_idx_d;
  logic [NUM_PERIPHERALS-1:0] hit;
  logic [DATA_WIDTH-1:0]      sel_dat;
  logic                       start, mapped_in, active, expired;
  logic                       sel_ack, sel_err;
  logic                       ack_d, err_d, cap, fault_set, fault_tmo_d;

  assign idx_in    = m_wb_adr_i[ADDR_SEL_LOW_BIT +: ADDR_SEL_BITS];
  assign mapped_in = ({1'b0, idx_in} < NUM_EXT);
  assign start     = m_wb_cyc_i & m_wb_stb_i;
  assign active    = (state == ST_ACTIVE);

  // Fan-out: address/data/control broadcast, cyc/stb only to the latched index.
  for (genvar k = 0; k < NUM_PERIPHERALS; k++) begin : g_slave
    assign hit[k]        = (idx_q == IDXW'(k));
    assign s_wb_cyc_o[k] = active & hit[k];
    assign s_wb_stb_o[k] = active & hit[k];
    assign s_wb_we_o[k]  = active & m_wb_we_i;
    assign s_wb_sel_o[k*SEL_WIDTH +: SEL_WIDTH]    = active ? m_wb_sel_i : '0;
    assign s_wb_adr_o[k*ADDR_WIDTH +: ADDR_WIDTH]  = active ? m_wb_adr_i : '0;
    assign s_wb_dat_o[k*DATA_WIDTH +: DATA_WIDTH]  = active ? m_wb_dat_i : '0;
  end

  // Responses from non-selected slaves are masked out here.
  assign sel_ack = |(s_wb_ack_i & hit);
  assign sel_err = |(s_wb_err_i & hit);

  always_comb begin
    sel_dat = '0;
    for (int k = 0; k < NUM_PERIPHERALS; k++) begin
      if (hit[k]) sel_dat = sel_dat | s_wb_dat_i[k*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  wb_tmo_counter #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .CNT_W          (CNT_W)
  ) u_tmo (
    .clk     (wb_clk_i),
    .rst     (wb_rst_i),
    .clr     (!active),
    .en      (active),
    .expired (expired)
  );

  // Priority in ACTIVE: abort > slave err > slave ack > timeout.
  always_comb begin
    state_d     = state;
    ack_d       = 1'b0;
    err_d       = 1'b0;
    cap         = 1'b0;
    fault_set   = 1'b0;
    fault_idx_d = idx_q;
    fault_tmo_d = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          if (mapped_in) begin
            state_d = ST_ACTIVE;
          end else begin
            state_d     = ST_RESP;
            err_d       = 1'b1;
            fault_set   = 1'b1;
            fault_idx_d = idx_in;
          end
        end
      end
      ST_ACTIVE: begin
        if (!m_wb_cyc_i) begin
          state_d = ST_IDLE;
        end else if (sel_err) begin
          state_d = ST_RESP;
          err_d   = 1'b1;
        end else if (sel_ack) begin
          state_d = ST_RESP;
          ack_d   = 1'b1;
          cap     = 1'b1;
        end else if (expired) begin
          state_d     = ST_RESP;
          err_d       = 1'b1;
          fault_set   = 1'b1;
          fault_tmo_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state       <= ST_IDLE;
      idx_q       <= '0;
      m_wb_ack_o  <= 1'b0;
      m_wb_err_o  <= 1'b0;
      m_wb_dat_o  <= '0;
      fault_o     <= 1'b0;
      fault_idx_o <= '0;
      fault_tmo_o <= 1'b0;
    end else begin
      state      <= state_d;
      m_wb_ack_o <= ack_d;
      m_wb_err_o <= err_d;
      if ((state == ST_IDLE) && start) idx_q <= idx_in;
      if (cap) m_wb_dat_o <= sel_dat;
      // First fault sticks; a clear in the same cycle lets the new fault in.
      if (fault_set && (!fault_o || fault_clr_i)) begin
        fault_o     <= 1'b1;
        fault_idx_o <= fault_idx_d;
        fault_tmo_o <= fault_tmo_d;
      end else if (fault_clr_i) begin
        fault_o     <= 1'b0;
        fault_idx_o <= '0;
        fault_tmo_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_wb_splitter_tmo.sv
module tb_wb_splitter_tmo;

  localparam int N   = 4;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int SW  = 4;
  localparam int IW  = 4;
  localparam int TMO = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic            m_cyc, m_stb, m_we;
  logic [SW-1:0]   m_sel;
  logic [AW-1:0]   m_adr;
  logic [DW-1:0]   m_dat_w;
  logic [DW-1:0]   m_dat_r;
  logic            m_ack, m_err;
  logic [N-1:0]    s_cyc, s_stb, s_we;
  logic [N*SW-1:0] s_sel;
  logic [N*AW-1:0] s_adr;
  logic [N*DW-1:0] s_dat_w;
  logic [N*DW-1:0] s_dat_r;
  logic [N-1:0]    s_ack, s_err;
  logic            fault, fault_tmo, fault_clr;
  logic [IW-1:0]   fault_idx;

  int n_checks = 0;
  int n_errors = 0;
  int n;

  always #5 clk = ~clk;

  wb_splitter_tmo #(
    .NUM_PERIPHERALS  (N),
    .ADDR_WIDTH       (AW),
    .DATA_WIDTH       (DW),
    .SEL_WIDTH        (SW),
    .ADDR_SEL_LOW_BIT (16),
    .ADDR_SEL_BITS    (IW),
    .TIMEOUT_CYCLES   (TMO)
  ) dut (
    .wb_clk_i    (clk),
    .wb_rst_i    (rst),
    .m_wb_cyc_i  (m_cyc),
    .m_wb_stb_i  (m_stb),
    .m_wb_we_i   (m_we),
    .m_wb_sel_i  (m_sel),
    .m_wb_adr_i  (m_adr),
    .m_wb_dat_i  (m_dat_w),
    .m_wb_dat_o  (m_dat_r),
    .m_wb_ack_o  (m_ack),
    .m_wb_err_o  (m_err),
    .s_wb_cyc_o  (s_cyc),
    .s_wb_stb_o  (s_stb),
    .s_wb_we_o   (s_we),
    .s_wb_sel_o  (s_sel),
    .s_wb_adr_o  (s_adr),
    .s_wb_dat_o  (s_dat_w),
    .s_wb_dat_i  (s_dat_r),
    .s_wb_ack_i  (s_ack),
    .s_wb_err_i  (s_err),
    .fault_o     (fault),
    .fault_idx_o (fault_idx),
    .fault_tmo_o (fault_tmo),
    .fault_clr_i (fault_clr)
  );

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_cyc(input logic [AW-1:0] adr, input logic we);
    m_cyc   = 1'b1;
    m_stb   = 1'b1;
    m_we    = we;
    m_sel   = 4'hF;
    m_adr   = adr;
    m_dat_w = 32'h5A5A_0000 | adr[15:0];
  endtask

  task automatic end_cyc();
    m_cyc = 1'b0;
    m_stb = 1'b0;
    m_we  = 1'b0;
    s_ack = '0;
    s_err = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; fault_clr = 1'b0;
    m_cyc = 0; m_stb = 0; m_we = 0; m_sel = '0; m_adr = '0; m_dat_w = '0;
    s_dat_r = '0; s_ack = '0; s_err = '0;
    tick(); tick();
    check_val("rst_ack_err", {m_ack, m_err}, 2'b00);
    check_val("rst_stb_cyc", {s_stb, s_cyc}, 8'h00);
    check_val("rst_dat", m_dat_r, 32'h0);
    check_val("rst_fault", {fault, fault_idx, fault_tmo}, 6'h00);
    rst = 1'b0;
    tick();

    // 1. Read idx 1, slave acks in the third ACTIVE cycle.
    start_cyc(32'h0001_0010, 1'b0);
    tick();
    check_val("t1_stb_c1", s_stb, 4'b0010);
    check_val("t1_cyc_c1", s_cyc, 4'b0010);
    check_val("t1_adr_bcast", s_adr[1*AW +: AW], 32'h0001_0010);
    tick();
    check_val("t1_stb_c2", s_stb, 4'b0010);
    tick();
    check_val("t1_stb_c3", s_stb, 4'b0010);
    check_val("t1_noack_yet", m_ack, 1'b0);
    s_ack[1] = 1'b1;
    s_dat_r[1*DW +: DW] = 32'hCAFE_F00D;
    tick();
    check_val("t1_ack", {m_ack, m_err}, 2'b10);
    check_val("t1_dat", m_dat_r, 32'hCAFE_F00D);
    check_val("t1_stb_dropped", s_stb, 4'b0000);
    end_cyc();
    tick();
    check_val("t1_ack_pulse", m_ack, 1'b0);

    // 2. Write to unmapped idx 5.
    start_cyc(32'h0005_0000, 1'b1);
    tick();
    check_val("t2_err", {m_ack, m_err}, 2'b01);
    check_val("t2_no_stb", s_stb, 4'b0000);
    check_val("t2_fault", {fault, fault_idx, fault_tmo}, {1'b1, 4'd5, 1'b0});
    end_cyc();
    tick();
    check_val("t2_err_pulse", m_err, 1'b0);
    check_val("t2_dat_kept", m_dat_r, 32'hCAFE_F00D);
    fault_clr = 1'b1;
    tick();
    fault_clr = 1'b0;
    check_val("t2_clr", {fault, fault_idx, fault_tmo}, 6'h00);

    // 3. Slave 2 never answers: err after TMO ACTIVE cycles.
    start_cyc(32'h0002_0000, 1'b0);
    tick();
    n = 0;
    while (m_err !== 1'b1 && n < 20) begin
      check_val("t3_stb_held", s_stb, 4'b0100);
      tick();
      n++;
    end
    check_val("t3_tmo_latency", n, TMO);
    check_val("t3_ack_low", m_ack, 1'b0);
    check_val("t3_fault", {fault, fault_idx, fault_tmo}, {1'b1, 4'd2, 1'b1});
    end_cyc();
    tick();
    fault_clr = 1'b1;
    tick();
    fault_clr = 1'b0;
    check_val("t3_clr", fault, 1'b0);

    // 4a. Slave 0 asserts ack and err together -> err only.
    start_cyc(32'h0000_0000, 1'b0);
    tick();
    s_ack[0] = 1'b1; s_err[0] = 1'b1;
    s_dat_r[0 +: DW] = 32'h1234_5678;
    tick();
    check_val("t4_err_wins", {m_ack, m_err}, 2'b01);
    check_val("t4_dat_kept", m_dat_r, 32'hCAFE_F00D);
    check_val("t4_no_fault", fault, 1'b0);
    end_cyc();
    tick();

    // 4b. Ack on the last timeout cycle (counter 7) -> ack, no fault.
    start_cyc(32'h0002_0040, 1'b0);
    tick();
    for (int i = 0; i < TMO - 1; i++) tick();
    check_val("t4_still_active", {s_stb, m_err}, {4'b0100, 1'b0});
    s_ack[2] = 1'b1;
    s_dat_r[2*DW +: DW] = 32'hA5A5_0007;
    tick();
    check_val("t4_late_ack", {m_ack, m_err}, 2'b10);
    check_val("t4_late_dat", m_dat_r, 32'hA5A5_0007);
    check_val("t4_late_nofault", fault, 1'b0);
    end_cyc();
    tick();

    // 5a. Master aborts in ACTIVE.
    start_cyc(32'h0001_0000, 1'b0);
    tick(); tick();
    end_cyc();
    tick();
    check_val("t5_abort_idle", {s_stb, m_ack, m_err}, 6'b0);
    tick();
    check_val("t5_abort_noresp", {m_ack, m_err}, 2'b00);

    // 5b. Reset pulse in ACTIVE.
    start_cyc(32'h0002_0000, 1'b0);
    tick();
    rst = 1'b1;
    tick();
    end_cyc();
    rst = 1'b0;
    check_val("t5_rst_idle", {s_stb, m_ack, m_err}, 6'b0);
    check_val("t5_rst_dat", m_dat_r, 32'h0);
    tick();
    check_val("t5_rst_noresp", {m_ack, m_err}, 2'b00);

    // 5c. Following read to idx 3 completes.
    start_cyc(32'h0003_0004, 1'b0);
    tick();
    check_val("t5_stb3", s_stb, 4'b1000);
    check_val("t5_adr3", s_adr[3*AW +: AW], 32'h0003_0004);
    s_ack[3] = 1'b1;
    s_dat_r[3*DW +: DW] = 32'h3333_0003;
    tick();
    check_val("t5_ack3", {m_ack, m_err}, 2'b10);
    check_val("t5_dat3", m_dat_r, 32'h3333_0003);
    end_cyc();
    tick();

    // 6. Sticky first fault, then set-wins over clear.
    start_cyc(32'h0007_0000, 1'b0);
    tick();
    check_val("t6_first", {fault, fault_idx, fault_tmo}, {1'b1, 4'd7, 1'b0});
    end_cyc();
    tick();
    start_cyc(32'h0009_0000, 1'b1);
    tick();
    check_val("t6_second_err", m_err, 1'b1);
    check_val("t6_sticky", {fault, fault_idx, fault_tmo}, {1'b1, 4'd7, 1'b0});
    end_cyc();
    tick();
    start_cyc(32'h000E_0000, 1'b0);
    fault_clr = 1'b1;
    tick();
    fault_clr = 1'b0;
    check_val("t6_set_wins", {fault, fault_idx, fault_tmo}, {1'b1, 4'hE, 1'b0});
    end_cyc();
    tick();
    check_val("t6_still_set", fault, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
